fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, drives the byte address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Handles hazard-unit stalls, branch/jump redirects resolved in EX, and halts cleanly when the PC runs past the end of instruction memory.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `IMEM_BYTES`, default 16: instruction memory size in bytes. Must be a multiple of 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hazard unit hold. Freezes the PC and IF/ID.
- `redirect`  in  1  branch taken or jump from EX.
- `redirect_pc`  in  64  target byte address for `redirect`.
- `imem_addr`  out  64  address to instruction memory; equals the current PC.
- `imem_instr`  in  32  combinational instruction word for `imem_addr`.
- `ifid_valid`  out  1  IF/ID holds a real instruction. A 0 means a bubble.
- `ifid_pc`  out  64  PC of the IF/ID instruction.
- `ifid_pc_plus4`  out  64  `ifid_pc + 4`, with modulo 2^64 wrap.
- `ifid_instr`  out  32  instruction word. Forced to NOP 32'h00000013 when `ifid_valid` is 0.
- `halted`  out  1  state is HALT.
- `misaligned`  out  1  sticky. Set when a redirect target has nonzero bits [1:0].
- `fetch_count`  out  32  number of valid instructions latched into IF/ID. Saturates at 32'hFFFFFFFF.

## Operation
- **State machine**: two states, RUN and HALT. Reset state is RUN.
- **Reset values** (applied on the edge where `reset_n` is 0):
  - pc = `RESET_PC`
  - `ifid_valid` = 0, `ifid_pc` = 0, `ifid_instr` = NOP
  - `halted` = 0, `misaligned` = 0, `fetch_count` = 0
- **Per-edge priority**: reset, then redirect, then stall, then advance. Only the first applicable rule takes effect.
- **Redirect** (wins over `stall`, because the EX branch is older than the stalled instruction):
  - pc = {`redirect_pc`[63:2], 2'b00}.
  - IF/ID is flushed to a bubble.
  - `misaligned` is set if `redirect_pc`[1:0] is nonzero.
  - The next state is RUN if the aligned target is below `IMEM_BYTES`; otherwise HALT.
- **Stall**: pc, IF/ID, state and `fetch_count` all hold.
- **Advance in RUN**:
  - If pc < `IMEM_BYTES`: IF/ID captures {1, pc, `imem_instr`}, pc becomes pc+4, and `fetch_count` increments.
  - If pc ≥ `IMEM_BYTES`: IF/ID becomes a bubble, pc holds, and the state goes to HALT.
- **Advance in HALT**: IF/ID stays a bubble and pc holds. Only a redirect or reset leaves HALT.
- **PC arithmetic**: 64-bit, modulo 2^64. A pc of 64'hFFFF_FFFF_FFFF_FFFC increments to 0, but because that pc is ≥ `IMEM_BYTES` the stage halts before ever incrementing it.
- **Bubbles**: `ifid_pc` and `ifid_pc_plus4` still update on a bubble (they take the flushed pc), but downstream must ignore them.

## Timing
- `imem_addr` is combinational from the pc register. The instruction at pc appears on the `ifid_*` outputs one cycle later.
- First valid IF/ID: on the first edge with `reset_n` = 1, `ifid_valid` rises for `RESET_PC`.
- Redirect sampled at edge N: IF/ID is a bubble after edge N, and the target instruction is valid after edge N+1. The redirect penalty is one bubble from this stage.
- Reset asserted mid-operation takes effect on the next edge, regardless of `stall` or `redirect`.
- All outputs are registered, except `imem_addr`, which comes directly from the pc register.

## Structure
- Shared pipeline package holds:
  - `XLEN` = 64
  - the `NOP_INSTR` constant 32'h00000013
  - the `fetch_state_t` enum {RUN, HALT}
  - the IF/ID bundle struct {valid, pc, pc_plus4, instr}, reused by decode.
- One sub-module, `if_id_reg`: the IF/ID bundle register with hold (stall) and flush (bubble) controls and reset to a bubble. `fetch_stage` keeps the PC, the FSM and the counters.

## Test plan
Memory image with `IMEM_BYTES` = 16: address 0 → 0x001001B3, 4 → 0x00318113, 8 → 0x00618213, 12 → 0x00318333.

1. **Straight line**: release reset, no stall.
   - `ifid_instr` = 0x001001B3, 0x00318113, 0x00618213, 0x00318333 on consecutive cycles, with `ifid_pc` = 0, 4, 8, 12.
   - Then a bubble, `halted` = 1, `fetch_count` = 4.
2. **Stall**: assert `stall` for 2 cycles after pc=4 is latched.
   - IF/ID holds 0x00318113 and pc=4 for 2 cycles; `imem_addr` holds 8.
   - The sequence then resumes at 8.
3. **Redirect vs stall**: `redirect`=1, `redirect_pc`=0, `stall`=1 in the same cycle while at pc=8.
   - The next cycle is a bubble; the cycle after has `ifid_pc`=0, `ifid_instr`=0x001001B3.
4. **Misaligned and out-of-range redirect**:
   - `redirect_pc`=6 → fetches 4 (0x00318113), `misaligned`=1 and stays 1.
   - `redirect_pc`=32 → HALT, bubbles, `fetch_count` frozen.
   - A later `redirect_pc`=12 → RUN, 0x00318333 latched.
5. **Mid-run reset**: drop `reset_n` for 1 cycle at pc=12 while `stall`=1.
   - All outputs return to their reset values: pc=0, `halted`=0, `fetch_count`=0.
   - Refetch starts from 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: datapath width, the NOP encoding, the fetch
// FSM states and the IF/ID bundle that decode also consumes.
package fetch_stage_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
  } ifid_t;

  // Bundle helper: pc_plus4 is always derived here so it can never disagree
  // with pc.
  function automatic ifid_t make_ifid(input logic v, input logic [XLEN-1:0] pc,
                                      input logic [31:0] instr);
    ifid_t b;
    b.valid    = v;
    b.pc       = pc;
    b.pc_plus4 = pc + 64'd4;
    b.instr    = v ? instr : NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control inputs, instruction-memory port and the
// IF/ID outputs. There is no valid/ready handshake: stall holds the stage for
// the cycle it is high, redirect is a one-cycle request that is always
// accepted and beats stall, and ifid_valid=0 marks a bubble.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_pc_plus4;
  logic [31:0]     ifid_instr;
  logic            halted;
  logic            misaligned;
  logic [31:0]     fetch_count;

  // The fetch stage side.
  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
           halted, misaligned, fetch_count
  );

  // The surrounding pipeline / memory side.
  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
           halted, misaligned, fetch_count
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: reset, flush (bubble), hold, load.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_hold,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output ifid_t           o_ifid
);

  ifid_t r_ifid;

  // Bundle register: a flush still records pc so the bubble carries an address.
  always_ff @(posedge clk) begin
    if (!reset_n)     r_ifid <= make_ifid(1'b0, '0, NOP_INSTR);
    else if (i_flush) r_ifid <= make_ifid(1'b0, i_pc, NOP_INSTR);
    else if (!i_hold) r_ifid <= make_ifid(1'b1, i_pc, i_instr);
  end

  assign o_ifid = r_ifid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, RUN/HALT FSM, sticky misalignment
// flag and saturating fetch counter. IF/ID itself lives in if_id_reg.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              IMEM_BYTES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus,
  output fetch_state_t  o_dbg_state
);

  localparam logic [XLEN-1:0] LP_IMEM_END = XLEN'(IMEM_BYTES);

  logic [XLEN-1:0] r_pc;
  fetch_state_t    r_state;
  logic            r_misaligned;
  logic [31:0]     r_fetch_count;

  fetch_state_t    w_next_state;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_target;
  logic            w_in_range;
  logic            w_fetch;
  logic            w_flush;
  logic            w_hold;
  ifid_t           w_ifid;

  assign w_target   = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_in_range = (r_pc < LP_IMEM_END);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_next_state;
  end

  // Next state and IF/ID control; redirect beats stall, stall beats advance.
  always_comb begin
    w_next_state = r_state;
    w_fetch      = 1'b0;
    w_flush      = 1'b0;
    w_hold       = 1'b0;
    w_next_pc    = r_pc;
    if (bus.redirect) begin
      w_flush      = 1'b1;
      w_next_pc    = w_target;
      w_next_state = (w_target < LP_IMEM_END) ? RUN : HALT;
    end else if (bus.stall) begin
      w_hold = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_in_range) begin
            w_fetch   = 1'b1;
            w_next_pc = r_pc + 64'd4;
          end else begin
            w_flush      = 1'b1;
            w_next_state = HALT;
          end
        end
        HALT:    w_flush = 1'b1;
        default: w_flush = 1'b1;
      endcase
    end
  end

  // PC, sticky misalignment flag and saturating fetch counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_misaligned  <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) r_misaligned <= 1'b1;
      if (w_fetch && (r_fetch_count != 32'hFFFF_FFFF))
        r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_hold  (w_hold),
    .i_flush (w_flush),
    .i_pc    (r_pc),
    .i_instr (bus.imem_instr),
    .o_ifid  (w_ifid)
  );

  assign bus.imem_addr     = r_pc;
  assign bus.ifid_valid    = w_ifid.valid;
  assign bus.ifid_pc       = w_ifid.pc;
  assign bus.ifid_pc_plus4 = w_ifid.pc_plus4;
  assign bus.ifid_instr    = w_ifid.instr;
  assign bus.halted        = (r_state == HALT);
  assign bus.misaligned    = r_misaligned;
  assign bus.fetch_count   = r_fetch_count;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by a random phase,
// all compared against a cycle-level model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  fetch_state_t dbg_state;
  int           checks = 0;
  int           errors = 0;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // instruction memory image
  logic [31:0] mem [4];
  always_comb begin
    if (bus.imem_addr < 64'd16) bus.imem_instr = mem[bus.imem_addr[3:2]];
    else                        bus.imem_instr = 32'hDEAD_BEEF;
  end

  // reference model state
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_halted;
  logic        m_mis;
  logic [31:0] m_cnt;

  task automatic model_edge(input logic rn, input logic st, input logic rd,
                            input logic [63:0] rp);
    logic [63:0] tgt;
    if (!rn) begin
      m_pc = 64'h0; m_valid = 0; m_ipc = 0; m_instr = NOP_INSTR;
      m_halted = 0; m_mis = 0; m_cnt = 0;
    end else if (rd) begin
      tgt = rp & ~64'd3;
      m_valid = 0; m_instr = NOP_INSTR; m_ipc = m_pc;
      if (rp % 4 != 0) m_mis = 1;
      m_halted = !(tgt < 64'd16);
      m_pc = tgt;
    end else if (st) begin
      // everything holds
    end else if (!m_halted && m_pc < 64'd16) begin
      m_valid = 1; m_ipc = m_pc; m_instr = mem[m_pc / 4];
      m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_valid = 0; m_ipc = m_pc; m_instr = NOP_INSTR; m_halted = 1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_addr", bus.imem_addr, m_pc);
    check("ifid_valid", 64'(bus.ifid_valid), 64'(m_valid));
    check("ifid_instr", 64'(bus.ifid_instr), 64'(m_instr));
    if (m_valid) begin
      check("ifid_pc", bus.ifid_pc, m_ipc);
      check("ifid_pc_plus4", bus.ifid_pc_plus4, m_ipc + 64'd4);
    end
    check("halted", 64'(bus.halted), 64'(m_halted));
    check("dbg_state", 64'(dbg_state == HALT), 64'(m_halted));
    check("misaligned", 64'(bus.misaligned), 64'(m_mis));
    check("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
  endtask

  // driver: apply inputs, take one edge, advance the model, compare
  task automatic step(input logic rn, input logic st, input logic rd,
                      input logic [63:0] rp);
    reset_n         = rn;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    @(posedge clk);
    model_edge(rn, st, rd, rp);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    mem[0] = 32'h001001B3; mem[1] = 32'h00318113;
    mem[2] = 32'h00618213; mem[3] = 32'h00318333;
    reset_n = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    #2;

    // reset values
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b1, 64'h8);
    check("reset_ifid_pc", bus.ifid_pc, 64'h0);
    check("reset_instr_nop", 64'(bus.ifid_instr), 64'h13);

    // 1. straight line to HALT
    run(1);
    check("first_instr", 64'(bus.ifid_instr), 64'h001001B3);
    run(4);
    check("sl_count", 64'(bus.fetch_count), 64'd4);
    run(2);
    check("sl_halted", 64'(bus.halted), 64'd1);

    // 2. stall after pc=4 latched
    step(1'b0, 1'b0, 1'b0, 64'h0);
    run(2);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("stall_addr", bus.imem_addr, 64'd8);
    check("stall_instr", 64'(bus.ifid_instr), 64'h00318113);
    run(1);
    check("resume_pc", bus.ifid_pc, 64'd8);

    // 3. redirect beats stall, from pc=8
    step(1'b0, 1'b0, 1'b0, 64'h0);
    run(2);
    step(1'b1, 1'b1, 1'b1, 64'h0);
    run(1);
    check("redir_instr", 64'(bus.ifid_instr), 64'h001001B3);
    run(1);

    // 4. misaligned and out-of-range redirects
    step(1'b1, 1'b0, 1'b1, 64'd6);
    run(1);
    check("mis_instr", 64'(bus.ifid_instr), 64'h00318113);
    check("mis_flag", 64'(bus.misaligned), 64'd1);
    step(1'b1, 1'b0, 1'b1, 64'd32);
    run(3);
    step(1'b1, 1'b0, 1'b1, 64'd12);
    run(1);
    check("oor_back_instr", 64'(bus.ifid_instr), 64'h00318333);

    // 5. mid-run reset while stalled at pc=12
    step(1'b1, 1'b0, 1'b1, 64'd12);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check("mid_reset_cnt", 64'(bus.fetch_count), 64'd0);
    run(2);

    // top-of-address-space target halts without wrapping
    step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    run(3);

    // random phase
    for (int i = 0; i < 600; i++) begin
      logic        rn, st, rd;
      logic [63:0] rp;
      rn = ($urandom_range(0, 49) != 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) rp = {$urandom, $urandom};
      else                           rp = 64'($urandom_range(0, 23));
      step(rn, st, rd, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
